// File: rtl/fetch_stage_param.sv
// ============================================================================
// Module   : fetch_stage_param
// Purpose  : Instruction-fetch stage: PC ownership, next-PC selection, optional
//            two-word immediate fetch and IF/ID pipeline register.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_stage_param #(
  parameter int          ADDR_W   = 32,
  parameter int          INSTR_W  = 16,
  parameter logic [31:0] RESET_PC = 32'h20,
  parameter int          PC_STEP  = 1,
  parameter bit          IMM_EN   = 1'b1,
  parameter int          IMM_BIT  = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imemAddr,
  output logic               imemCs,
  input  logic [INSTR_W-1:0] imemData,
  input  logic               stall,
  input  logic               flush,
  input  logic               jumpEn,
  input  logic [ADDR_W-1:0]  jumpAddress,
  input  logic               intReq,
  input  logic [ADDR_W-1:0]  intRegAddress,
  output logic               ifIdValid,
  output logic [INSTR_W-1:0] ifIdInstr,
  output logic [INSTR_W-1:0] ifIdImm,
  output logic               isImmediate,
  output logic [ADDR_W-1:0]  nextInstructionAddress,
  output logic [4:0]         opCode,
  output logic [2:0]         Rs,
  output logic [2:0]         Rd,
  output logic [4:0]         SHMNT
);

  localparam logic [ADDR_W-1:0] C_RESET_PC = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] C_PC_STEP  = ADDR_W'(PC_STEP);

  localparam logic [0:0] S_INSTR = 1'b0;
  localparam logic [0:0] S_IMM   = 1'b1;

  logic [0:0]         r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_pending;
  logic [ADDR_W-1:0]  r_pending_addr;
  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [INSTR_W-1:0] r_imm;
  logic               r_is_imm;
  logic [ADDR_W-1:0]  r_nia;

  logic [0:0]         w_state_nxt;
  logic [ADDR_W-1:0]  w_pc_nxt;
  logic [ADDR_W-1:0]  w_pc_inc;
  logic               w_valid_nxt;
  logic               w_capture;
  logic               w_emit_single;
  logic               w_emit_pair;
  logic               w_has_imm;

  assign w_pc_inc = r_pc + C_PC_STEP;

  generate
    if (IMM_EN) begin : g_imm_en
      assign w_has_imm = imemData[IMM_BIT];
    end else begin : g_imm_dis
      assign w_has_imm = 1'b0;
    end
  endgenerate

  // State, PC and IF/ID registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_INSTR;
      r_pc           <= C_RESET_PC;
      r_pending      <= '0;
      r_pending_addr <= '0;
      r_valid        <= 1'b0;
      r_instr        <= '0;
      r_imm          <= '0;
      r_is_imm       <= 1'b0;
      r_nia          <= C_RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_valid <= w_valid_nxt;
      if (w_capture) begin
        r_pending      <= imemData;
        r_pending_addr <= r_pc;
      end
      if (w_emit_single) begin
        r_instr  <= imemData;
        r_imm    <= '0;
        r_is_imm <= 1'b0;
        r_nia    <= w_pc_inc;
      end
      if (w_emit_pair) begin
        r_instr  <= r_pending;
        r_imm    <= imemData;
        r_is_imm <= 1'b1;
        r_nia    <= w_pc_inc;
      end
    end
  end

  // Next-state selection: interrupt > jump > flush > stall > normal
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_valid_nxt   = r_valid;
    w_capture     = 1'b0;
    w_emit_single = 1'b0;
    w_emit_pair   = 1'b0;
    if (intReq) begin
      w_pc_nxt    = intRegAddress;
      w_state_nxt = S_INSTR;
      w_valid_nxt = 1'b0;
    end else if (jumpEn) begin
      w_pc_nxt    = jumpAddress;
      w_state_nxt = S_INSTR;
      w_valid_nxt = 1'b0;
    end else if (flush) begin
      // A half-fetched instruction restarts from its first word
      if (r_state == S_IMM) begin
        w_pc_nxt = r_pending_addr;
      end
      w_state_nxt = S_INSTR;
      w_valid_nxt = 1'b0;
    end else if (!stall) begin
      case (r_state)
        S_INSTR: begin
          w_pc_nxt = w_pc_inc;
          if (w_has_imm) begin
            w_capture   = 1'b1;
            w_state_nxt = S_IMM;
            w_valid_nxt = 1'b0;
          end else begin
            w_emit_single = 1'b1;
            w_valid_nxt   = 1'b1;
          end
        end
        S_IMM: begin
          w_emit_pair = 1'b1;
          w_pc_nxt    = w_pc_inc;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_INSTR;
        end
        default: begin
          w_state_nxt = S_INSTR;
        end
      endcase
    end
  end

  always_comb begin
    imemAddr               = r_pc;
    imemCs                 = rst_n;
    ifIdValid              = r_valid;
    ifIdInstr              = r_instr;
    ifIdImm                = r_imm;
    isImmediate            = r_is_imm;
    nextInstructionAddress = r_nia;
    opCode                 = r_instr[15:11];
    Rs                     = r_instr[10:8];
    Rd                     = r_instr[7:5];
    SHMNT                  = r_instr[4:0];
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage_param.sv
// ============================================================================
// Module   : tb_fetch_stage_param
// Purpose  : Directed plus random checks of fetch_stage_param against a
//            word-level fetch model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage_param;

  localparam int AW = 32;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] imemAddr;
  logic          imemCs;
  logic [IW-1:0] imemData;
  logic          stall, flush, jumpEn, intReq;
  logic [AW-1:0] jumpAddress, intRegAddress;
  logic          ifIdValid, isImmediate;
  logic [IW-1:0] ifIdInstr, ifIdImm;
  logic [AW-1:0] nextInstructionAddress;
  logic [4:0]    opCode, SHMNT;
  logic [2:0]    Rs, Rd;

  fetch_stage_param dut (
    .clk(clk), .rst_n(rst_n),
    .imemAddr(imemAddr), .imemCs(imemCs), .imemData(imemData),
    .stall(stall), .flush(flush),
    .jumpEn(jumpEn), .jumpAddress(jumpAddress),
    .intReq(intReq), .intRegAddress(intRegAddress),
    .ifIdValid(ifIdValid), .ifIdInstr(ifIdInstr), .ifIdImm(ifIdImm),
    .isImmediate(isImmediate), .nextInstructionAddress(nextInstructionAddress),
    .opCode(opCode), .Rs(Rs), .Rd(Rd), .SHMNT(SHMNT)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:255];
  always_comb imemData = mem[imemAddr[7:0]];

  // Reference model: where fetch is, whether an instruction is half-read,
  // and what the IF/ID register should be showing.
  logic [AW-1:0] m_pc, m_start, m_nia;
  logic          m_partial, m_valid, m_isimm;
  logic [IW-1:0] m_instr, m_imm;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h20; m_start = '0; m_partial = 1'b0; m_valid = 1'b0;
    m_instr = '0; m_imm = '0; m_isimm = 1'b0; m_nia = 32'h20;
  endtask

  task automatic model_edge(input bit st, input bit fl, input bit jp, input logic [AW-1:0] ja,
                            input bit ir, input logic [AW-1:0] ia);
    logic [15:0] w;
    if (ir || jp) begin
      m_pc = ir ? ia : ja;
      m_partial = 1'b0;
      m_valid = 1'b0;
    end else if (fl) begin
      if (m_partial) m_pc = m_start;
      m_partial = 1'b0;
      m_valid = 1'b0;
    end else if (!st) begin
      if (!m_partial) begin
        w = mem[m_pc[7:0]];
        if (w[15]) begin
          m_start = m_pc; m_partial = 1'b1; m_valid = 1'b0;
          m_pc = m_pc + 1;
        end else begin
          m_instr = w; m_imm = '0; m_isimm = 1'b0;
          m_pc = m_pc + 1; m_nia = m_pc; m_valid = 1'b1;
        end
      end else begin
        m_instr = mem[m_start[7:0]]; m_imm = mem[m_pc[7:0]]; m_isimm = 1'b1;
        m_pc = m_pc + 1; m_nia = m_pc; m_valid = 1'b1; m_partial = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    check_eq("imemAddr", imemAddr, m_pc);
    check_eq("imemCs", imemCs, 1'b1);
    check_eq("ifIdValid", ifIdValid, m_valid);
    check_eq("ifIdInstr", ifIdInstr, m_instr);
    check_eq("ifIdImm", ifIdImm, m_imm);
    check_eq("isImmediate", isImmediate, m_isimm);
    check_eq("nextInstrAddr", nextInstructionAddress, m_nia);
    check_eq("opCode", opCode, m_instr[15:11]);
    check_eq("Rs", Rs, m_instr[10:8]);
    check_eq("Rd", Rd, m_instr[7:5]);
    check_eq("SHMNT", SHMNT, m_instr[4:0]);
  endtask

  // Called just after a sampling point; drives, clocks once, then checks.
  task automatic step(input bit st, input bit fl, input bit jp, input logic [AW-1:0] ja,
                      input bit ir, input logic [AW-1:0] ia);
    stall = st; flush = fl; jumpEn = jp; jumpAddress = ja; intReq = ir; intRegAddress = ia;
    @(posedge clk);
    model_edge(st, fl, jp, ja, ir, ia);
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".cs"}, imemCs, 1'b0);
    check_eq({tag, ".addr"}, imemAddr, 32'h20);
    check_eq({tag, ".valid"}, ifIdValid, 1'b0);
    check_eq({tag, ".instr"}, ifIdInstr, 16'h0);
    check_eq({tag, ".imm"}, ifIdImm, 16'h0);
    check_eq({tag, ".isimm"}, isImmediate, 1'b0);
    check_eq({tag, ".nia"}, nextInstructionAddress, 32'h20);
  endtask

  // Entered one time unit after a rising edge; asserts and releases
  // reset between edges so no clock edge sees it.
  task automatic async_reset();
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    #2 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      if ($urandom_range(3) != 0) mem[i][15] = 1'b0;
    end
    mem[8'h20] = 16'h0A45; mem[8'h21] = 16'h1234; mem[8'h22] = 16'h2345;
    mem[8'h30] = 16'h9ABC; mem[8'h31] = 16'h5555;
    mem[8'hFF] = 16'h1234;

    rst_n = 1'b0; stall = 0; flush = 0; jumpEn = 0; intReq = 0;
    jumpAddress = '0; intRegAddress = '0;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("por");
    rst_n = 1'b1;
    model_reset();
    check_eq("first_addr", imemAddr, 32'h20);

    // Sequential single-word fetch
    step(0, 0, 0, '0, 0, '0);
    check_eq("t1.valid", ifIdValid, 1'b1);
    check_eq("t1.instr", ifIdInstr, 16'h0A45);
    check_eq("t1.opCode", opCode, 5'd1);
    check_eq("t1.Rs", Rs, 3'd2);
    check_eq("t1.Rd", Rd, 3'd2);
    check_eq("t1.SHMNT", SHMNT, 5'd5);
    check_eq("t1.nia", nextInstructionAddress, 32'h21);
    check_eq("t1.addr1", imemAddr, 32'h21);
    step(0, 0, 0, '0, 0, '0);
    check_eq("t1.addr2", imemAddr, 32'h22);
    check_eq("t1.instr2", ifIdInstr, 16'h1234);

    // Two-word fetch from reset, then stall at 0x24
    async_reset();
    mem[8'h20] = 16'h8000; mem[8'h21] = 16'hBEEF;
    mem[8'h22] = 16'h1111; mem[8'h23] = 16'h2222; mem[8'h24] = 16'h3333;
    step(0, 0, 0, '0, 0, '0);
    check_eq("t2.bubble", ifIdValid, 1'b0);
    step(0, 0, 0, '0, 0, '0);
    check_eq("t2.valid", ifIdValid, 1'b1);
    check_eq("t2.instr", ifIdInstr, 16'h8000);
    check_eq("t2.imm", ifIdImm, 16'hBEEF);
    check_eq("t2.isimm", isImmediate, 1'b1);
    check_eq("t2.nia", nextInstructionAddress, 32'h22);
    run(2);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, '0, 0, '0);
      check_eq("t3.stall_addr", imemAddr, 32'h24);
      check_eq("t3.stall_instr", ifIdInstr, 16'h2222);
    end
    step(0, 0, 0, '0, 0, '0);
    check_eq("t3.resume_instr", ifIdInstr, 16'h3333);
    check_eq("t3.resume_nia", nextInstructionAddress, 32'h25);

    // Interrupt beats a simultaneous jump
    step(0, 0, 1, 32'h100, 1, 32'h10);
    check_eq("t4.addr", imemAddr, 32'h10);
    check_eq("t4.valid", ifIdValid, 1'b0);
    run(1);

    // Flush during the immediate word re-fetches from the first word
    step(0, 0, 1, 32'h30, 0, '0);
    step(0, 0, 0, '0, 0, '0);
    check_eq("t5.simm_addr", imemAddr, 32'h31);
    step(0, 1, 0, '0, 0, '0);
    check_eq("t5.flush_valid", ifIdValid, 1'b0);
    check_eq("t5.flush_addr", imemAddr, 32'h30);
    run(2);
    check_eq("t5.instr", ifIdInstr, 16'h9ABC);
    check_eq("t5.imm", ifIdImm, 16'h5555);
    check_eq("t5.nia", nextInstructionAddress, 32'h32);

    // PC wrap
    step(0, 0, 1, 32'hFFFF_FFFF, 0, '0);
    step(0, 0, 0, '0, 0, '0);
    check_eq("t6.nia", nextInstructionAddress, 32'h0);
    check_eq("t6.addr", imemAddr, 32'h0);

    // Async reset while waiting for the immediate word
    step(0, 0, 1, 32'h30, 0, '0);
    step(0, 0, 0, '0, 0, '0);
    async_reset();
    run(2);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      logic [AW-1:0] ja, ia;
      ja = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : 32'($urandom_range(255));
      ia = 32'($urandom_range(255));
      step($urandom_range(4) == 0, $urandom_range(15) == 0, $urandom_range(24) == 0, ja,
           $urandom_range(49) == 0, ia);
      if ($urandom_range(199) == 0) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
